// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard interface: decoded instruction fields in, pipeline control and statistics out.
interface hazard_scoreboard_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_is_branch;
    logic             id_is_store;
    logic             id_regwrite;
    logic             id_memread;
    logic [REG_W-1:0] id_dst;
    logic             id_branch_taken;
    logic             pc_hold;
    logic             ifid_hold;
    logic             idex_bubble;
    logic             if_flush;
    logic             busy;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch,
               id_is_store, id_regwrite, id_memread, id_dst, id_branch_taken,
        input  pc_hold, ifid_hold, idex_bubble, if_flush, busy, stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch,
               id_is_store, id_regwrite, id_memread, id_dst, id_branch_taken,
        output pc_hold, ifid_hold, idex_bubble, if_flush, busy, stall_count, flush_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register pending-cycle scoreboard deciding ID-stage stalls and taken-branch flushes.
module hazard_scoreboard #(
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    hazard_scoreboard_if.slave sb
);
    localparam int         NREG     = 1 << REG_W;
    localparam logic [2:0] ALU_SET  = 3'd1;
    localparam logic [2:0] LOAD_SET = 3'(1 + LOAD_LAT);

    logic [2:0]       pend [NREG];
    logic [2:0]       p_rs;
    logic [2:0]       p_rt;
    logic             haz_rs;
    logic             haz_rt;
    logic             stall;
    logic             flush;
    logic             issue;
    logic             any_pend;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    assign p_rs = pend[sb.id_rs];
    assign p_rt = pend[sb.id_rt];

    // Branches compare in ID so need the value fully settled; store data is consumed
    // one stage later than ALU operands, so it tolerates one more pending cycle.
    always_comb begin
        haz_rs = 1'b0;
        haz_rt = 1'b0;
        if (sb.id_uses_rs && sb.id_rs != '0)
            haz_rs = sb.id_is_branch ? (p_rs != 3'd0) : (p_rs > 3'd1);
        if (sb.id_uses_rt && sb.id_rt != '0) begin
            if (sb.id_is_branch)     haz_rt = (p_rt != 3'd0);
            else if (sb.id_is_store) haz_rt = (p_rt > 3'd2);
            else                     haz_rt = (p_rt > 3'd1);
        end
    end

    assign stall = !reset && sb.id_valid && (haz_rs || haz_rt);
    assign flush = !reset && sb.id_valid && sb.id_is_branch && sb.id_branch_taken && !stall;
    assign issue = sb.id_valid && !stall;

    assign pend[0] = 3'd0;

    for (genvar r = 1; r < NREG; r++) begin : g_ent
        always_ff @(posedge clk) begin
            if (reset)
                pend[r] <= 3'd0;
            else if (issue && sb.id_regwrite && sb.id_dst == REG_W'(r))
                pend[r] <= sb.id_memread ? LOAD_SET : ALU_SET;
            else if (pend[r] != 3'd0)
                pend[r] <= pend[r] - 3'd1;
        end
    end

    always_comb begin
        any_pend = 1'b0;
        for (int r = 1; r < NREG; r++)
            any_pend = any_pend | (pend[r] != 3'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (flush && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign sb.pc_hold     = stall;
    assign sb.ifid_hold   = stall;
    assign sb.idex_bubble = stall;
    assign sb.if_flush    = flush;
    assign sb.busy        = any_pend;
    assign sb.stall_count = stall_cnt;
    assign sb.flush_count = flush_cnt;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and random checks of hazard_scoreboard against a timestamp-based hazard model.
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, v, urs, urt, br, stor, rw, mr, tk;
    logic [4:0] rs, rt, dst;

    hazard_scoreboard_if #(.REG_W(5), .CNT_W(16)) i1 ();
    hazard_scoreboard_if #(.REG_W(5), .CNT_W(16)) i3 ();
    hazard_scoreboard_if #(.REG_W(5), .CNT_W(4))  i4 ();

    assign i1.id_valid = v;  assign i3.id_valid = v;  assign i4.id_valid = v;
    assign i1.id_rs = rs;    assign i3.id_rs = rs;    assign i4.id_rs = rs;
    assign i1.id_rt = rt;    assign i3.id_rt = rt;    assign i4.id_rt = rt;
    assign i1.id_uses_rs = urs; assign i3.id_uses_rs = urs; assign i4.id_uses_rs = urs;
    assign i1.id_uses_rt = urt; assign i3.id_uses_rt = urt; assign i4.id_uses_rt = urt;
    assign i1.id_is_branch = br; assign i3.id_is_branch = br; assign i4.id_is_branch = br;
    assign i1.id_is_store = stor; assign i3.id_is_store = stor; assign i4.id_is_store = stor;
    assign i1.id_regwrite = rw; assign i3.id_regwrite = rw; assign i4.id_regwrite = rw;
    assign i1.id_memread = mr;  assign i3.id_memread = mr;  assign i4.id_memread = mr;
    assign i1.id_dst = dst;     assign i3.id_dst = dst;     assign i4.id_dst = dst;
    assign i1.id_branch_taken = tk; assign i3.id_branch_taken = tk; assign i4.id_branch_taken = tk;

    hazard_scoreboard #(.REG_W(5), .LOAD_LAT(1), .CNT_W(16)) u1 (.clk(clk), .reset(rst), .sb(i1));
    hazard_scoreboard #(.REG_W(5), .LOAD_LAT(3), .CNT_W(16)) u3 (.clk(clk), .reset(rst), .sb(i3));
    hazard_scoreboard #(.REG_W(5), .LOAD_LAT(1), .CNT_W(4))  u4 (.clk(clk), .reset(rst), .sb(i4));

    logic [2:0]  o_ph, o_ih, o_ib, o_fl, o_bz;
    logic [15:0] o_sc [3];
    logic [15:0] o_fc [3];
    assign o_ph = {i4.pc_hold, i3.pc_hold, i1.pc_hold};
    assign o_ih = {i4.ifid_hold, i3.ifid_hold, i1.ifid_hold};
    assign o_ib = {i4.idex_bubble, i3.idex_bubble, i1.idex_bubble};
    assign o_fl = {i4.if_flush, i3.if_flush, i1.if_flush};
    assign o_bz = {i4.busy, i3.busy, i1.busy};
    assign o_sc[0] = i1.stall_count; assign o_sc[1] = i3.stall_count; assign o_sc[2] = {12'b0, i4.stall_count};
    assign o_fc[0] = i1.flush_count; assign o_fc[1] = i3.flush_count; assign o_fc[2] = {12'b0, i4.flush_count};

    // Model: a register written at ID-cycle t becomes usable a fixed number of cycles later;
    // the remaining wait at cycle c is derived from the timestamp, not tracked as a counter.
    int n_cmp = 0, n_mis = 0, cyc = 0;
    int lat_of [3] = '{1, 3, 1};
    int cmax   [3] = '{65535, 65535, 15};
    int wlat [3][32];
    int wt   [3][32];
    int scnt [3];
    int fcnt [3];

    function automatic int remaining(int k, int r);
        int d;
        if (r == 0 || wlat[k][r] == 0) return 0;
        d = wlat[k][r] - (cyc - wt[k][r] - 1);
        return (d < 0) ? 0 : d;
    endfunction

    function automatic bit src_hazard(int k, bit used, int r, bit is_rt);
        int p;
        if (!used || r == 0) return 0;
        p = remaining(k, r);
        if (br) return p != 0;
        if (is_rt && stor) return p > 2;
        return p > 1;
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic step(output logic [2:0] st, output logic [2:0] fl);
        bit es [3];
        bit ef [3];
        bit eb;
        #1;
        for (int k = 0; k < 3; k++) begin
            es[k] = !rst && v && (src_hazard(k, urs, rs, 0) || src_hazard(k, urt, rt, 1));
            ef[k] = !rst && v && br && tk && !es[k];
            eb = 0;
            for (int r = 1; r < 32; r++) if (remaining(k, r) != 0) eb = 1;
            chk("pc_hold", k, 32'(o_ph[k]), 32'(es[k]));
            chk("ifid_hold", k, 32'(o_ih[k]), 32'(es[k]));
            chk("idex_bubble", k, 32'(o_ib[k]), 32'(es[k]));
            chk("if_flush", k, 32'(o_fl[k]), 32'(ef[k]));
            chk("busy", k, 32'(o_bz[k]), 32'(eb));
            chk("stall_count", k, 32'(o_sc[k]), 32'(scnt[k]));
            chk("flush_count", k, 32'(o_fc[k]), 32'(fcnt[k]));
            st[k] = o_ph[k];
            fl[k] = o_fl[k];
        end
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                for (int r = 0; r < 32; r++) wlat[k][r] = 0;
                scnt[k] = 0;
                fcnt[k] = 0;
            end else begin
                if (es[k] && scnt[k] < cmax[k]) scnt[k]++;
                if (ef[k] && fcnt[k] < cmax[k]) fcnt[k]++;
                if (v && !es[k] && rw && dst != 0) begin
                    wlat[k][dst] = mr ? 1 + lat_of[k] : 1;
                    wt[k][dst]   = cyc;
                end
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic instr(input bit iv, input int irs, input int irt, input bit iurs, input bit iurt,
                         input bit ibr, input bit ist, input bit irw, input bit imr, input int idst,
                         input bit itk);
        v = iv; rs = 5'(irs); rt = 5'(irt); urs = iurs; urt = iurt; br = ibr;
        stor = ist; rw = irw; mr = imr; dst = 5'(idst); tk = itk;
    endtask

    task automatic nop();
        instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Hold the current instruction until instance k issues it; n counts its stall cycles.
    task automatic hold_until(input int k, output int n, output logic fl_issue);
        logic [2:0] st, fl;
        bit done = 0;
        n = 0;
        fl_issue = 0;
        for (int i = 0; i < 30 && !done; i++) begin
            step(st, fl);
            if (!st[k]) begin
                done = 1;
                fl_issue = fl[k];
            end else n++;
        end
        if (!done) begin
            n_mis++;
            $display("FAIL hold_timeout[%0d] observed=still_stalled expected=issue", k);
        end
    endtask

    task automatic drain();
        logic [2:0] st, fl;
        nop();
        repeat (8) step(st, fl);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] st, fl;
        logic       f;
        int         n;
        for (int k = 0; k < 3; k++) begin
            scnt[k] = 0; fcnt[k] = 0;
            for (int r = 0; r < 32; r++) begin wlat[k][r] = 0; wt[k][r] = 0; end
        end
        rst = 1'b1;
        nop();
        @(negedge clk);
        step(st, fl);
        step(st, fl);
        rst = 1'b0;
        step(st, fl);

        // lw $7; add $10,$7,$0
        instr(1, 0, 0, 0, 0, 0, 0, 1, 1, 7, 0); step(st, fl);
        instr(1, 7, 0, 1, 0, 0, 0, 1, 0, 10, 0); hold_until(0, n, f);
        chk("alu_after_load_stalls", 0, n, 1);
        #1 chk("alu_after_load_stall_count", 0, o_sc[0], 1);
        drain();

        // lw $1; sw $1,0($2) -> store data forwarded, no stall
        instr(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0); step(st, fl);
        instr(1, 2, 1, 1, 1, 0, 1, 0, 0, 0, 0); hold_until(0, n, f);
        chk("store_data_after_load_stalls", 0, n, 0);
        // lw $1; sw $2,0($1) -> address base must wait
        instr(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0); step(st, fl);
        instr(1, 1, 2, 1, 1, 0, 1, 0, 0, 0, 0); hold_until(0, n, f);
        chk("store_base_after_load_stalls", 0, n, 1);
        drain();

        // add $14; beq $14,$8 taken
        instr(1, 3, 4, 1, 1, 0, 0, 1, 0, 14, 0); step(st, fl);
        instr(1, 14, 8, 1, 1, 1, 0, 0, 0, 0, 1); hold_until(0, n, f);
        chk("branch_after_alu_stalls", 0, n, 1);
        chk("branch_after_alu_flush", 0, 32'(f), 1);
        nop();
        #1 chk("flush_count_after_branch", 0, o_fc[0], 1);
        step(st, fl);
        chk("flush_one_cycle", 0, 32'(fl[0]), 0);
        drain();

        // lw $9; beq $9,$0 taken
        instr(1, 0, 0, 0, 0, 0, 0, 1, 1, 9, 0); step(st, fl);
        instr(1, 9, 0, 1, 1, 1, 0, 0, 0, 0, 1); hold_until(0, n, f);
        chk("branch_after_load_stalls", 0, n, 2);
        chk("branch_after_load_flush", 0, 32'(f), 1);
        // write to $0 then branch on $0
        instr(1, 3, 4, 1, 1, 0, 0, 1, 1, 0, 0); step(st, fl);
        instr(1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0); hold_until(0, n, f);
        chk("zero_reg_never_stalls", 0, n, 0);
        drain();

        // LOAD_LAT=3 instance
        instr(1, 0, 0, 0, 0, 0, 0, 1, 1, 5, 0); step(st, fl);
        instr(1, 5, 6, 1, 1, 0, 0, 1, 0, 11, 0); hold_until(1, n, f);
        chk("lat3_alu_after_load_stalls", 1, n, 3);
        drain();
        instr(1, 0, 0, 0, 0, 0, 0, 1, 1, 5, 0); step(st, fl);
        instr(1, 6, 5, 1, 1, 1, 0, 0, 0, 0, 0); hold_until(1, n, f);
        chk("lat3_branch_after_load_stalls", 1, n, 4);
        drain();

        // reset during second branch stall
        instr(1, 0, 0, 0, 0, 0, 0, 1, 1, 9, 0); step(st, fl);
        instr(1, 9, 0, 1, 1, 1, 0, 0, 0, 0, 1); step(st, fl);
        chk("pre_reset_first_stall", 0, 32'(st[0]), 1);
        rst = 1'b1;
        #1;
        chk("reset_pc_hold", 0, 32'(o_ph[0]), 0);
        chk("reset_if_flush", 0, 32'(o_fl[0]), 0);
        step(st, fl);
        rst = 1'b0;
        #1;
        chk("post_reset_busy", 0, 32'(o_bz[0]), 0);
        chk("post_reset_stall", 0, 32'(o_ph[0]), 0);
        chk("post_reset_stall_count", 0, o_sc[0], 0);
        chk("post_reset_flush_count", 0, o_fc[0], 0);
        step(st, fl);
        drain();

        // 20 load-use pairs saturate the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            instr(1, 0, 0, 0, 0, 0, 0, 1, 1, 3, 0); step(st, fl);
            instr(1, 3, 0, 1, 0, 0, 0, 1, 0, 12, 0); hold_until(2, n, f);
        end
        nop();
        #1 chk("stall_count_saturates", 2, o_sc[2], 15);
        drain();

        // random traffic on a small register window
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            instr($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 1));
            step(st, fl);
        end
        rst = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameters, one per line:
- REG_W, default 5, register-address width; scoreboard covers 2^REG_W registers.
- LOAD_LAT, default 1, legal 1..6, extra cycles before load data is forwardable.
- CNT_W, default 16, statistics counter width.
REQ-002 SHALL have ports, one per line:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_rs  in  REG_W  source register rs.
- id_rt  in  REG_W  source register rt.
- id_uses_rs  in  1  instruction reads rs.
- id_uses_rt  in  1  instruction reads rt.
- id_is_branch  in  1  branch resolved in ID (beq/bne).
- id_is_store  in  1  store; rt is store data.
- id_regwrite  in  1  instruction writes a register.
- id_memread  in  1  instruction is a load.
- id_dst  in  REG_W  destination register.
- id_branch_taken  in  1  ID branch comparison result.
- pc_hold  out  1  freeze PC.
- ifid_hold  out  1  freeze IF/ID.
- idex_bubble  out  1  load NOP into ID/EX.
- if_flush  out  1  squash IF/ID contents next edge.
- busy  out  1  any scoreboard entry nonzero.
- stall_count  out  CNT_W  stall cycles since reset.
- flush_count  out  CNT_W  taken-branch flushes since reset.

Function
REQ-003 SHALL keep one 3-bit pending counter pend[r] per register.
- pend[0] SHALL always read 0 and never be written.
REQ-004 Issue SHALL mean id_valid=1 and stall=0 in the same cycle.
REQ-005 On issue with id_regwrite=1 and id_dst!=0, at the next edge:
- pend[id_dst] SHALL be set to 1+LOAD_LAT if id_memread=1, otherwise to 1.
REQ-006 Every other nonzero pend[r] SHALL decrement by 1 per cycle, including stall cycles.
- For the destination being set, the set SHALL override the decrement.
REQ-007 A used source s SHALL cause a stall when:
- id_is_branch=1 and pend[s]!=0; or
- s is rt with id_is_store=1 and id_is_branch=0, and pend[s]>2; or
- otherwise, pend[s]>1.
- A source with its uses flag=0, or with index 0, SHALL never stall.
REQ-008 stall SHALL be 0 when id_valid=0.
- stall SHALL be combinational from the pend state and the current ID inputs; zero added latency.
REQ-009 While stall=1, pc_hold, ifid_hold and idex_bubble SHALL all be 1; otherwise all 0.
REQ-010 if_flush SHALL be 1 exactly when id_valid=1, id_is_branch=1, id_branch_taken=1 and stall=0.
- A stalled branch SHALL never flush.
REQ-011 if_flush and stall SHALL never both be 1.
REQ-012 stall_count SHALL increment once per cycle with stall=1.
- flush_count SHALL increment once per cycle with if_flush=1.
- Both SHALL saturate at all-ones; no wrap-around.
REQ-013 busy SHALL be the OR-reduction of all pend entries.
REQ-014 With LOAD_LAT=1, the block SHALL produce exactly:
- 1 stall for an ALU consumer after a load;
- 0 stalls for store data after a load;
- 1 stall for a branch after an ALU write;
- 2 stalls for a branch after a load.

Reset
REQ-015 While reset=1 at a clock edge, all pend entries and both counters SHALL clear to 0 at that edge.
REQ-016 While reset=1, pc_hold, ifid_hold, idex_bubble and if_flush SHALL be forced to 0.
REQ-017 Reset asserted mid-stall SHALL discard all pending hazards.
- The first post-reset cycle SHALL show busy=0 and no stall.

Verification
REQ-018 Bench SHALL cover, with LOAD_LAT=1 unless stated:
- lw $7 issued, then add reading $7 -> exactly 1 stall cycle, stall_count=1, then issue.
- lw $1, then sw with rt=$1 and rs=$2 -> 0 stalls; then sw with rs=$1 directly after a new lw $1 -> 1 stall.
- add $14, then beq $14,$8 taken -> 1 stall, then if_flush=1 for 1 cycle, flush_count=1.
- lw $9, then beq $9,$0 -> 2 stall cycles, if_flush stays 0 until the stalls end; writes to $0 never stall.
- LOAD_LAT=3: lw $5, then sub reading $5 -> 3 stalls; branch reading $5 -> 4 stalls.
- reset asserted during the 2nd branch stall -> outputs 0 that cycle, busy=0 next cycle, counters 0.
- CNT_W=4 with continuous stalls -> stall_count holds at 15.
